// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: funct3 encodings, opcodes, LSU state type, request legality check.
// Latency: none (types, constants and a pure function only).
// Backpressure: n/a. Misaligned halfword/word handling is selected by LSU_MISALIGN_TRAP_EN.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Decides whether a request may touch memory at all.
    function automatic logic lsu_req_legal(input logic we, input logic [2:0] funct3,
                                           input logic [1:0] offset);
        logic ok;
        if (we) begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (((funct3 == F3_H) || (funct3 == F3_HU)) && offset[0]) ok = 1'b0;
        if ((funct3 == F3_W) && (offset != 2'b00)) ok = 1'b0;
`else
        if (offset == 2'b11) ok = ok; // offset fully handled by lsu_offset_fix
`endif
        return ok;
    endfunction

    // Drops the low address bits a naturally-aligned access cannot use.
    function automatic logic [1:0] lsu_offset_fix(input logic [2:0] funct3, input logic [1:0] offset);
        logic [1:0] fixed;
        case (funct3)
            F3_B, F3_BU: fixed = offset;
            F3_H, F3_HU: fixed = {offset[1], 1'b0};
            default:     fixed = 2'b00;
        endcase
        return fixed;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  be,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: enables and replicated data for the addressed lanes.
    always_comb begin
        be       = 4'b1111;
        st_lanes = st_data;
        case (funct3)
            F3_B, F3_BU: begin
                be       = 4'b0001 << offset;
                st_lanes = {4{st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be       = offset[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                st_lanes = st_data;
            end
        endcase
    end

    // Load side: pick the addressed byte/halfword and extend it.
    always_comb begin
        ld_byte = ld_raw[7:0];
        case (offset)
            2'd0:    ld_byte = ld_raw[7:0];
            2'd1:    ld_byte = ld_raw[15:8];
            2'd2:    ld_byte = ld_raw[23:16];
            default: ld_byte = ld_raw[31:24];
        endcase
        ld_half = offset[1] ? ld_raw[31:16] : ld_raw[15:0];
        case (funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'h0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'h0, ld_half};
            F3_W:    ld_data = ld_raw;
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: ALU address -> word memory req/gnt/rvalid, aligned+extended load data back.
// Latency: store 2 cycles, load 3 cycles, illegal 1 cycle (min); TIMEOUT-cycle abort on a stuck memory.
// Backpressure: req_ready only in IDLE; stall holds the core until the RESP cycle. LSU_MISALIGN_TRAP_EN traps misalignment.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state_q, state_n;
    logic [7:0]  tmo_cnt_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic        req_legal;
    logic        timed_out;
    logic        rsp_err_n;
    logic [31:0] rsp_rdata_n;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign req_legal = lsu_req_legal(req_we, req_funct3, req_addr[1:0]);
    assign timed_out = (tmo_cnt_q >= 8'(TIMEOUT - 1));

    lsu_align u_align (
        .funct3   (funct3_q),
        .offset   (offset_q),
        .st_data  (wdata_q),
        .ld_raw   (mem_rdata),
        .be       (lane_be),
        .st_lanes (lane_wdata),
        .ld_data  (load_data)
    );

    // Next state plus the response payload captured on entry to RESP.
    // A grant or read data arriving in the last allowed cycle wins over the timeout.
    always_comb begin
        state_n     = state_q;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = 32'h0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        state_n = REQ;
                    end else begin
                        state_n   = RESP;
                        rsp_err_n = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_n = mem_we ? RESP : WAIT;
                end else if (timed_out) begin
                    state_n   = RESP;
                    rsp_err_n = 1'b1;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_n     = RESP;
                    rsp_rdata_n = load_data;
                end else if (timed_out) begin
                    state_n   = RESP;
                    rsp_err_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, timeout counter, captured request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmo_cnt_q <= 8'h0;
            funct3_q  <= 3'b000;
            offset_q  <= 2'b00;
            wdata_q   <= 32'h0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            state_q   <= state_n;
            tmo_cnt_q <= ((state_q == REQ) || (state_q == WAIT)) ? tmo_cnt_q + 8'd1 : 8'h0;
            if ((state_q == IDLE) && req_valid && req_legal) begin
                funct3_q <= req_funct3;
                offset_q <= lsu_offset_fix(req_funct3, req_addr[1:0]);
                wdata_q  <= req_wdata;
                mem_we   <= req_we;
                mem_addr <= {req_addr[31:2], 2'b00};
            end
            mem_req   <= (state_n == REQ);
            rsp_valid <= (state_n == RESP);
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

    assign mem_wdata = lane_wdata;
    assign mem_be    = lane_be & {4{mem_we}};
    assign req_ready = (state_q == IDLE);
    assign stall     = ((state_q == IDLE) && req_valid) || (state_q == REQ) || (state_q == WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a response scoreboard plus reset/timeout sequences.
// Latency: checks exact response cycle, mem_req window and stall per transaction.
// Backpressure: memory grant/rvalid timing is scripted per vector.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, stall;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          gnt_cyc, rv_cyc;          // 0 = never asserted
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_rsp_cyc;
        int          exp_req_first, exp_req_cnt; // first = -1 when no memory access
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwdata;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(string n, logic we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rdata, int gnt, int rv,
                                logic [31:0] erd, logic eerr, int ersp, int rfirst, int rcnt,
                                logic [31:0] maddr, logic [3:0] be, logic [31:0] mwd);
        vec_t v;
        v.name = n; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.gnt_cyc = gnt; v.rv_cyc = rv; v.exp_rdata = erd; v.exp_err = eerr;
        v.exp_rsp_cyc = ersp; v.exp_req_first = rfirst; v.exp_req_cnt = rcnt;
        v.exp_maddr = maddr; v.exp_be = be; v.exp_mwdata = mwd;
        return v;
    endfunction

    // Drives one transaction from the cycle after the call (posedge+1) until its response.
    task automatic run_vec(input vec_t v);
        int   first, cnt, rsp_cyc;
        logic stall_bad;
        exp_t e;
        first = -1; cnt = 0; rsp_cyc = -1; stall_bad = 1'b0;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata; mem_rdata = v.rdata;
        for (int cyc = 0; cyc < 30; cyc++) begin
            mem_gnt    = (v.gnt_cyc != 0) && (cyc == v.gnt_cyc);
            mem_rvalid = (v.rv_cyc != 0) && (cyc == v.rv_cyc);
            @(negedge clk);
            if (mem_req === 1'b1) begin
                if (first < 0) begin
                    first = cyc;
                    chk({v.name, " mem_addr"}, mem_addr, v.exp_maddr);
                    chk({v.name, " mem_we"}, 32'(mem_we), 32'(v.we));
                    if (v.we) begin
                        chk({v.name, " mem_be"}, 32'(mem_be), 32'(v.exp_be));
                        chk({v.name, " mem_wdata"}, mem_wdata, v.exp_mwdata);
                    end
                end
                cnt++;
            end
            if (stall !== (cyc < v.exp_rsp_cyc)) stall_bad = 1'b1;
            if (rsp_valid === 1'b1) begin
                rsp_cyc = cyc;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s sb_empty: got response with no expectation queued", v.name);
                end else begin
                    e = sb_q.pop_front();
                    chk({v.name, " rsp_rdata"}, rsp_rdata, e.rdata);
                    chk({v.name, " rsp_err"}, 32'(rsp_err), 32'(e.err));
                end
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (rsp_cyc >= 0) break;
        end
        chk({v.name, " rsp_cycle"}, 32'(rsp_cyc), 32'(v.exp_rsp_cyc));
        chk({v.name, " req_first"}, 32'(first), 32'(v.exp_req_first));
        chk({v.name, " req_cnt"}, 32'(cnt), 32'(v.exp_req_cnt));
        chk({v.name, " stall"}, 32'(stall_bad), 32'd0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        //           name         we f3      addr     wdata         rdata        gnt rv exp_rdata     err rsp first cnt maddr   be       mwdata
        vecs.push_back(mk("lb_103",  0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 1, 2, 32'hFFFFFF80, 0, 3, 1, 1, 32'h100, 4'b0000, 32'h0));
        vecs.push_back(mk("lhu_102", 0, 3'b101, 32'h102, 32'h0,        32'h8001ABCD, 1, 2, 32'h00008001, 0, 3, 1, 1, 32'h100, 4'b0000, 32'h0));
        vecs.push_back(mk("lh_102",  0, 3'b001, 32'h102, 32'h0,        32'h8001ABCD, 1, 2, 32'hFFFF8001, 0, 3, 1, 1, 32'h100, 4'b0000, 32'h0));
        vecs.push_back(mk("lbu_101", 0, 3'b100, 32'h101, 32'h0,        32'h80FF1234, 1, 3, 32'h00000012, 0, 4, 1, 1, 32'h100, 4'b0000, 32'h0));
        vecs.push_back(mk("lb_102",  0, 3'b000, 32'h102, 32'h0,        32'h80FF1234, 1, 2, 32'hFFFFFFFF, 0, 3, 1, 1, 32'h100, 4'b0000, 32'h0));
        vecs.push_back(mk("sb_201",  1, 3'b000, 32'h201, 32'h123456A5, 32'h0,        4, 0, 32'h0,        0, 5, 1, 4, 32'h200, 4'b0010, 32'hA5A5A5A5));
        vecs.push_back(mk("sh_302",  1, 3'b001, 32'h302, 32'h1234BEEF, 32'h0,        1, 0, 32'h0,        0, 2, 1, 1, 32'h300, 4'b1100, 32'hBEEFBEEF));
        vecs.push_back(mk("sw_040",  1, 3'b010, 32'h040, 32'hDEADBEEF, 32'h0,        1, 0, 32'h0,        0, 2, 1, 1, 32'h040, 4'b1111, 32'hDEADBEEF));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk("lw_106",  0, 3'b010, 32'h106, 32'h0,        32'h12345678, 1, 2, 32'h0,        1, 1, -1, 0, 32'h0,  4'b0000, 32'h0));
        vecs.push_back(mk("lh_103",  0, 3'b001, 32'h103, 32'h0,        32'h8001ABCD, 1, 2, 32'h0,        1, 1, -1, 0, 32'h0,  4'b0000, 32'h0));
`else
        vecs.push_back(mk("lw_106",  0, 3'b010, 32'h106, 32'h0,        32'h12345678, 1, 2, 32'h12345678, 0, 3, 1, 1, 32'h104, 4'b0000, 32'h0));
        vecs.push_back(mk("lh_103",  0, 3'b001, 32'h103, 32'h0,        32'h8001ABCD, 1, 2, 32'hFFFF8001, 0, 3, 1, 1, 32'h100, 4'b0000, 32'h0));
`endif
        vecs.push_back(mk("st_f3_011", 1, 3'b011, 32'h300, 32'h0,      32'h0,        1, 0, 32'h0,        1, 1, -1, 0, 32'h0,   4'b0000, 32'h0));
        vecs.push_back(mk("ld_f3_110", 0, 3'b110, 32'h300, 32'h0,      32'h0,        1, 2, 32'h0,        1, 1, -1, 0, 32'h0,   4'b0000, 32'h0));
        vecs.push_back(mk("sw_tmo",    1, 3'b010, 32'h500, 32'h1,      32'h0,        0, 0, 32'h0,        1, 5, 1, 4, 32'h500,  4'b1111, 32'h1));
        vecs.push_back(mk("lw_rv_gnt", 0, 3'b010, 32'h600, 32'h0,      32'hCAFEF00D, 1, 1, 32'h0,        1, 5, 1, 1, 32'h600,  4'b0000, 32'h0));

        // Reset state: checked while reset is held and again right after release.
        repeat (3) @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            chk($sformatf("reset%0d req_ready", pass), 32'(req_ready), 32'd1);
            chk($sformatf("reset%0d rsp_valid", pass), 32'(rsp_valid), 32'd0);
            chk($sformatf("reset%0d rsp_rdata", pass), rsp_rdata, 32'h0);
            chk($sformatf("reset%0d rsp_err", pass), 32'(rsp_err), 32'd0);
            chk($sformatf("reset%0d stall", pass), 32'(stall), 32'd0);
            chk($sformatf("reset%0d mem_ctl", pass), {29'h0, mem_req, mem_we, 1'b0}, 32'h0);
            chk($sformatf("reset%0d mem_addr", pass), mem_addr, 32'h0);
            chk($sformatf("reset%0d mem_wdata", pass), mem_wdata, 32'h0);
            chk($sformatf("reset%0d mem_be", pass), 32'(mem_be), 32'h0);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end

        // Back-to-back through the table; each request starts the cycle after the previous RESP.
        foreach (vecs[i]) run_vec(vecs[i]);

        // Read-data timeout followed by a late rvalid that must be dropped.
        run_vec(mk("lw_wait_tmo", 0, 3'b010, 32'h600, 32'h0, 32'hCAFEF00D, 1, 0, 32'h0, 1, 5, 1, 1, 32'h600, 4'b0000, 32'h0));
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            mem_rvalid = 1'b1;
            @(negedge clk);
            if ((rsp_valid !== 1'b0) || (req_ready !== 1'b1)) bad++;
            @(posedge clk);
            #1;
        end
        mem_rvalid = 1'b0;
        chk("late_rvalid ignored", 32'(bad), 32'd0);

        // Reset while waiting for read data.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h700;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        chk("rst_wait mem_req_c1", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        mem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_wait stall_c2", 32'(stall), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        chk("rst_wait mem_req_c3", 32'(mem_req), 32'd0);
        chk("rst_wait req_ready_c3", 32'(req_ready), 32'd1);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid !== 1'b0) bad++;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            @(negedge clk);
        end
        chk("rst_wait no_rsp", 32'(bad), 32'd0);
        @(posedge clk); #1;

        // A request right after the reset still completes normally.
        run_vec(mk("sb_post_rst", 1, 3'b000, 32'h203, 32'h0000005A, 32'h0, 1, 0, 32'h0, 0, 2, 1, 1, 32'h200, 4'b1000, 32'h5A5A5A5A));

        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
